axi_hdmi_tx_buf_rd: RTL and testbench
=====================================

AXI_HDMI_TX_BUF_RD -- requirements
Module: axi_hdmi_tx_buf_rd

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named hdmi_clk and hdmi_rst_n.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- hdmi_clk, in, 1: pixel clock.
- hdmi_rst_n, in, 1: async active-low reset.
- hdmi_fs, in, 1: one-cycle frame-start pulse from the timing generator.
- hdmi_de, in, 1: active-pixel request, one pixel per cycle.
- vdma_fs_ret_toggle, in, 1: frame-return toggle, vdma domain.
- vdma_fs_waddr, in, 9: frame start write address; stable whenever vdma_fs_ret_toggle changes.
- hdmi_fs_toggle, out, 1: frame-start toggle to the vdma domain.
- hdmi_raddr_g, out, 9: Gray-coded read address to the vdma domain.
- hdmi_raddr, out, 9: line-buffer RAM read address.
- hdmi_rdata, in, 48: RAM read data, two 24-bit pixels, valid 1 cycle after hdmi_raddr.
- hdmi_data, out, 24: output pixel.
- hdmi_data_valid, out, 1: hdmi_data qualifier.
- hdmi_fs_ret, out, 1: one-cycle pulse, synchronized frame return.
- hdmi_fs_miss, out, 1: one-cycle pulse, frame start with no return available.

Function
REQ-003 On hdmi_fs=1, hdmi_fs_toggle SHALL invert on the next edge.
REQ-004 vdma_fs_ret_toggle SHALL pass through flops m1, m2, m3; hdmi_fs_ret SHALL be registered m2 XOR m3.
REQ-005 When m2 XOR m3 is 1, the block SHALL capture vdma_fs_waddr into hdmi_fs_waddr (internal) and set ret_pending.
REQ-006 The state machine SHALL have three states: IDLE, WAIT, ACTIVE.
REQ-007 IDLE: on hdmi_fs, the state SHALL go to WAIT.
REQ-008 WAIT or ACTIVE: on hdmi_fs with ret_pending=1, the block SHALL:
- go to ACTIVE;
- load hdmi_raddr from hdmi_fs_waddr;
- clear ret_pending;
- clear pixel select sel.
REQ-009 WAIT or ACTIVE: on hdmi_fs with ret_pending=0, the state SHALL go to WAIT and hdmi_fs_miss SHALL pulse for 1 cycle.
REQ-010 hdmi_fs and a synchronized return in the same cycle: the return SHALL NOT be used for this frame start. It SHALL set ret_pending for the next frame start, and REQ-009 applies.
REQ-011 In ACTIVE, each hdmi_de cycle SHALL toggle sel. When sel=1, hdmi_raddr SHALL increment by 1 modulo 512 (511 wraps to 0).
REQ-012 hdmi_fs has priority over hdmi_de in the same cycle: the address load wins, and no increment or sel toggle occurs.
REQ-013 In IDLE and WAIT, hdmi_raddr and sel SHALL hold.
REQ-014 hdmi_raddr_g SHALL be a registered binary-to-Gray conversion of hdmi_raddr, with 1-cycle lag.
REQ-015 Data pipeline latency is 2 cycles from hdmi_de to hdmi_data_valid:
- stage 1 registers de, sel and the ACTIVE flag;
- stage 2 registers hdmi_data_valid = de_d1;
- hdmi_data = stage-1 sel ? hdmi_rdata[47:24] : hdmi_rdata[23:0] if ACTIVE was set at stage 1, else 24'd0.
REQ-016 hdmi_data_valid SHALL follow hdmi_de in every state; in non-ACTIVE states it is paired with zero data.

Reset
REQ-017 While hdmi_rst_n=0, all flops SHALL clear asynchronously:
- state=IDLE;
- hdmi_fs_toggle=0, hdmi_raddr=0, hdmi_raddr_g=0;
- hdmi_data=0, hdmi_data_valid=0;
- hdmi_fs_ret=0, hdmi_fs_miss=0;
- ret_pending=0, sel=0, sync flops=0.
REQ-018 Reset deassertion SHALL be synchronous to hdmi_clk. Reset mid-frame SHALL abandon the frame; the first hdmi_fs after release enters WAIT.

Structure
REQ-019 A shared package SHALL hold:
- the state enumeration (IDLE, WAIT, ACTIVE);
- address width 9, pixel width 24, RAM word width 48;
- the RAM read latency of 1.
REQ-020 The toggle synchronizer SHALL be one sub-module, ad_toggle_sync (3 flops plus edge pulse output). Binary-to-Gray conversion SHALL be an inline function.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Release reset, first hdmi_fs -> hdmi_fs_toggle 0->1, state WAIT, hdmi_data_valid tracks de with data 0.
- Toggle vdma_fs_ret_toggle with vdma_fs_waddr=9'h1F0, then hdmi_fs -> hdmi_fs_ret pulse 3 cycles later, hdmi_raddr=0x1F0, ACTIVE.
- Thirty-two de cycles from 0x1FE -> addresses 0x1FE, 0x1FF, 0x000…; hdmi_raddr_g=0x100 when raddr=0x1FF; pixels alternate low/high halves at 2-cycle latency.
- hdmi_fs without a return -> hdmi_fs_miss pulse, state WAIT, data zeroed.
- hdmi_fs in the same cycle as the synchronized return -> hdmi_fs_miss; the next hdmi_fs loads the captured address.
- hdmi_rst_n low mid-line -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/axi_hdmi_tx_buf_rd_pkg.sv
// Shared types and sizes for the HDMI transmit line-buffer read side.
package axi_hdmi_tx_buf_rd_pkg;

  localparam int unsigned AddrWidth    = 9;
  localparam int unsigned PixelWidth   = 24;
  localparam int unsigned RamWidth     = 2 * PixelWidth;
  localparam int unsigned RamRdLatency = 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StActive = 2'd2
  } state_e;

endpackage

// File: rtl/ad_toggle_sync.sv
// Three-flop toggle synchronizer; pulse_o is high for one cycle per input toggle.
module ad_toggle_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic toggle_i,
  output logic pulse_o
);

  logic m1_q, m2_q, m3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m1_q <= 1'b0;
      m2_q <= 1'b0;
      m3_q <= 1'b0;
    end else begin
      m1_q <= toggle_i;
      m2_q <= m1_q;
      m3_q <= m2_q;
    end
  end

  assign pulse_o = m2_q ^ m3_q;

endmodule

// File: rtl/axi_hdmi_tx_buf_rd.sv
// HDMI-side reader of the VDMA line buffer: frame handshake, address generation
// and two-pixels-per-word unpacking.
module axi_hdmi_tx_buf_rd
  import axi_hdmi_tx_buf_rd_pkg::*;
(
  input  logic                  hdmi_clk,
  input  logic                  hdmi_rst_n,
  input  logic                  hdmi_fs,
  input  logic                  hdmi_de,
  input  logic                  vdma_fs_ret_toggle,
  input  logic [AddrWidth-1:0]  vdma_fs_waddr,
  output logic                  hdmi_fs_toggle,
  output logic [AddrWidth-1:0]  hdmi_raddr_g,
  output logic [AddrWidth-1:0]  hdmi_raddr,
  input  logic [RamWidth-1:0]   hdmi_rdata,
  output logic [PixelWidth-1:0] hdmi_data,
  output logic                  hdmi_data_valid,
  output logic                  hdmi_fs_ret,
  output logic                  hdmi_fs_miss
);

  function automatic logic [AddrWidth-1:0] bin2gray(input logic [AddrWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  state_e               state_q;
  logic                 sel_q;
  logic                 ret_pending_q;
  logic [AddrWidth-1:0] fs_waddr_q;
  logic                 fs_ret_edge;
  logic                 de_d1_q, sel_d1_q, active_d1_q;

  ad_toggle_sync u_fs_ret_sync (
    .clk_i    (hdmi_clk),
    .rst_ni   (hdmi_rst_n),
    .toggle_i (vdma_fs_ret_toggle),
    .pulse_o  (fs_ret_edge)
  );

  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      hdmi_fs_toggle <= 1'b0;
      hdmi_fs_ret    <= 1'b0;
      hdmi_raddr_g   <= '0;
    end else begin
      if (hdmi_fs) hdmi_fs_toggle <= ~hdmi_fs_toggle;
      hdmi_fs_ret  <= fs_ret_edge;
      hdmi_raddr_g <= bin2gray(hdmi_raddr);
    end
  end

  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      state_q       <= StIdle;
      hdmi_raddr    <= '0;
      sel_q         <= 1'b0;
      ret_pending_q <= 1'b0;
      fs_waddr_q    <= '0;
      hdmi_fs_miss  <= 1'b0;
    end else begin
      hdmi_fs_miss <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hdmi_fs) state_q <= StWait;
        end
        StWait, StActive: begin
          if (hdmi_fs) begin
            if (ret_pending_q) begin
              state_q       <= StActive;
              hdmi_raddr    <= fs_waddr_q;
              ret_pending_q <= 1'b0;
              sel_q         <= 1'b0;
            end else begin
              state_q      <= StWait;
              hdmi_fs_miss <= 1'b1;
            end
          end else if ((state_q == StActive) && hdmi_de) begin
            sel_q <= ~sel_q;
            if (sel_q) hdmi_raddr <= hdmi_raddr + 9'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // A return arriving with hdmi_fs is kept for the following frame start.
      if (fs_ret_edge) begin
        ret_pending_q <= 1'b1;
        fs_waddr_q    <= vdma_fs_waddr;
      end
    end
  end

  // Stage 1 lines up with the RAM read latency; stage 2 selects the pixel half.
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      de_d1_q         <= 1'b0;
      sel_d1_q        <= 1'b0;
      active_d1_q     <= 1'b0;
      hdmi_data_valid <= 1'b0;
      hdmi_data       <= '0;
    end else begin
      de_d1_q         <= hdmi_de;
      sel_d1_q        <= sel_q;
      active_d1_q     <= (state_q == StActive);
      hdmi_data_valid <= de_d1_q;
      if (!active_d1_q) begin
        hdmi_data <= '0;
      end else if (sel_d1_q) begin
        hdmi_data <= hdmi_rdata[RamWidth-1:PixelWidth];
      end else begin
        hdmi_data <= hdmi_rdata[PixelWidth-1:0];
      end
    end
  end

endmodule

// File: tb/tb_axi_hdmi_tx_buf_rd.sv
// Directed bench for axi_hdmi_tx_buf_rd with a one-cycle-latency line-buffer RAM model.
module tb_axi_hdmi_tx_buf_rd;
  import axi_hdmi_tx_buf_rd_pkg::*;

  logic        hdmi_clk = 1'b0;
  logic        hdmi_rst_n = 1'b0;
  logic        hdmi_fs = 1'b0;
  logic        hdmi_de = 1'b0;
  logic        vdma_fs_ret_toggle = 1'b0;
  logic [8:0]  vdma_fs_waddr = '0;
  logic        hdmi_fs_toggle;
  logic [8:0]  hdmi_raddr_g;
  logic [8:0]  hdmi_raddr;
  logic [47:0] hdmi_rdata = '0;
  logic [23:0] hdmi_data;
  logic        hdmi_data_valid;
  logic        hdmi_fs_ret;
  logic        hdmi_fs_miss;

  int   n_tests = 0;
  int   n_fail = 0;
  logic exp_tog = 1'b0;

  axi_hdmi_tx_buf_rd dut (
    .hdmi_clk           (hdmi_clk),
    .hdmi_rst_n         (hdmi_rst_n),
    .hdmi_fs            (hdmi_fs),
    .hdmi_de            (hdmi_de),
    .vdma_fs_ret_toggle (vdma_fs_ret_toggle),
    .vdma_fs_waddr      (vdma_fs_waddr),
    .hdmi_fs_toggle     (hdmi_fs_toggle),
    .hdmi_raddr_g       (hdmi_raddr_g),
    .hdmi_raddr         (hdmi_raddr),
    .hdmi_rdata         (hdmi_rdata),
    .hdmi_data          (hdmi_data),
    .hdmi_data_valid    (hdmi_data_valid),
    .hdmi_fs_ret        (hdmi_fs_ret),
    .hdmi_fs_miss       (hdmi_fs_miss)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  // Each RAM word tags both pixel halves with the address they came from.
  always @(posedge hdmi_clk) hdmi_rdata <= {8'hB0, 7'd0, hdmi_raddr, 8'hA0, 7'd0, hdmi_raddr};

  task automatic tick();
    @(posedge hdmi_clk);
    #1;
  endtask

  task automatic fs_cycle();
    hdmi_fs = 1'b1;
    tick();
    hdmi_fs = 1'b0;
    exp_tog = ~exp_tog;
  endtask

  task automatic send_return(input logic [8:0] addr);
    vdma_fs_waddr      = addr;
    vdma_fs_ret_toggle = ~vdma_fs_ret_toggle;
  endtask

  function automatic logic [8:0] exp_addr(input int k);
    logic [8:0] a;
    a = 9'h1FE + 9'(k / 2);
    return a;
  endfunction

  task automatic test_reset();
    hdmi_rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (hdmi_fs_toggle !== 1'b0) begin
      n_fail++; $display("FAIL reset_fs_toggle: got %b want 0", hdmi_fs_toggle);
    end
    n_tests++;
    if (hdmi_raddr !== 9'h000 || hdmi_raddr_g !== 9'h000) begin
      n_fail++; $display("FAIL reset_raddr: got %h/%h want 000/000", hdmi_raddr, hdmi_raddr_g);
    end
    n_tests++;
    if (hdmi_data !== 24'h0 || hdmi_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: got %h/%b want 0/0", hdmi_data, hdmi_data_valid);
    end
    n_tests++;
    if (hdmi_fs_ret !== 1'b0 || hdmi_fs_miss !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b/%b want 0/0", hdmi_fs_ret, hdmi_fs_miss);
    end
    n_tests++;
    if (dut.state_q !== StIdle) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, StIdle);
    end
    hdmi_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_fs();
    fs_cycle();
    n_tests++;
    if (hdmi_fs_toggle !== 1'b1) begin
      n_fail++; $display("FAIL first_fs_toggle: got %b want 1", hdmi_fs_toggle);
    end
    n_tests++;
    if (dut.state_q !== StWait) begin
      n_fail++; $display("FAIL first_fs_state: got %0d want %0d", dut.state_q, StWait);
    end
    n_tests++;
    if (hdmi_fs_miss !== 1'b0) begin
      n_fail++; $display("FAIL first_fs_miss: got %b want 0", hdmi_fs_miss);
    end
    hdmi_de = 1'b1;
    tick();
    hdmi_de = 1'b0;
    tick();
    n_tests++;
    if (hdmi_data_valid !== 1'b1 || hdmi_data !== 24'h0) begin
      n_fail++; $display("FAIL wait_data: got %b/%h want 1/000000", hdmi_data_valid, hdmi_data);
    end
    tick();
    n_tests++;
    if (hdmi_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_valid_drop: got %b want 0", hdmi_data_valid);
    end
  endtask

  task automatic test_return();
    send_return(9'h1F0);
    tick();
    tick();
    n_tests++;
    if (hdmi_fs_ret !== 1'b0) begin
      n_fail++; $display("FAIL fs_ret_early: got %b want 0", hdmi_fs_ret);
    end
    tick();
    n_tests++;
    if (hdmi_fs_ret !== 1'b1) begin
      n_fail++; $display("FAIL fs_ret_pulse: got %b want 1", hdmi_fs_ret);
    end
    tick();
    n_tests++;
    if (hdmi_fs_ret !== 1'b0) begin
      n_fail++; $display("FAIL fs_ret_width: got %b want 0", hdmi_fs_ret);
    end
    fs_cycle();
    n_tests++;
    if (dut.state_q !== StActive || hdmi_raddr !== 9'h1F0) begin
      n_fail++; $display("FAIL ret_load: got st %0d addr %h want %0d 1f0",
                         dut.state_q, hdmi_raddr, StActive);
    end
    n_tests++;
    if (hdmi_fs_miss !== 1'b0 || hdmi_fs_toggle !== exp_tog) begin
      n_fail++; $display("FAIL ret_fs_flags: got miss %b tog %b want 0 %b",
                         hdmi_fs_miss, hdmi_fs_toggle, exp_tog);
    end
    tick();
    n_tests++;
    if (hdmi_raddr_g !== 9'h108) begin
      n_fail++; $display("FAIL ret_gray: got %h want 108", hdmi_raddr_g);
    end
  endtask

  task automatic test_line();
    logic [8:0]  a;
    logic [23:0] px;
    send_return(9'h1FE);
    repeat (4) tick();
    fs_cycle();
    n_tests++;
    if (dut.state_q !== StActive || hdmi_raddr !== 9'h1FE) begin
      n_fail++; $display("FAIL line_load: got st %0d addr %h want %0d 1fe",
                         dut.state_q, hdmi_raddr, StActive);
    end
    for (int k = 0; k < 34; k++) begin
      hdmi_de = (k < 32);
      a = exp_addr((k < 32) ? k : 32);
      n_tests++;
      if (hdmi_raddr !== a) begin
        n_fail++; $display("FAIL line_addr[%0d]: got %h want %h", k, hdmi_raddr, a);
      end
      if (k >= 1) begin
        a = exp_addr((k - 1 < 32) ? k - 1 : 32);
        a = a ^ (a >> 1);
        n_tests++;
        if (hdmi_raddr_g !== a) begin
          n_fail++; $display("FAIL line_gray[%0d]: got %h want %h", k, hdmi_raddr_g, a);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (hdmi_raddr_g !== 9'h100) begin
          n_fail++; $display("FAIL gray_1ff: got %h want 100", hdmi_raddr_g);
        end
      end
      if (k >= 2) begin
        a  = exp_addr(k - 2);
        px = ((k - 2) % 2 == 1) ? {8'hB0, 7'd0, a} : {8'hA0, 7'd0, a};
        n_tests++;
        if (hdmi_data_valid !== 1'b1 || hdmi_data !== px) begin
          n_fail++; $display("FAIL line_pixel[%0d]: got %b/%h want 1/%h",
                             k - 2, hdmi_data_valid, hdmi_data, px);
        end
      end
      tick();
    end
    hdmi_de = 1'b0;
  endtask

  task automatic test_miss();
    fs_cycle();
    n_tests++;
    if (hdmi_fs_miss !== 1'b1 || dut.state_q !== StWait) begin
      n_fail++; $display("FAIL miss_pulse: got miss %b st %0d want 1 %0d",
                         hdmi_fs_miss, dut.state_q, StWait);
    end
    n_tests++;
    if (hdmi_fs_toggle !== exp_tog || hdmi_raddr !== 9'h00E) begin
      n_fail++; $display("FAIL miss_hold: got tog %b addr %h want %b 00e",
                         hdmi_fs_toggle, hdmi_raddr, exp_tog);
    end
    hdmi_de = 1'b1;
    tick();
    hdmi_de = 1'b0;
    n_tests++;
    if (hdmi_fs_miss !== 1'b0) begin
      n_fail++; $display("FAIL miss_width: got %b want 0", hdmi_fs_miss);
    end
    tick();
    n_tests++;
    if (hdmi_data_valid !== 1'b1 || hdmi_data !== 24'h0 || hdmi_raddr !== 9'h00E) begin
      n_fail++; $display("FAIL miss_data: got %b/%h addr %h want 1/000000 00e",
                         hdmi_data_valid, hdmi_data, hdmi_raddr);
    end
  endtask

  task automatic test_same_cycle();
    send_return(9'h055);
    tick();
    tick();
    fs_cycle();
    n_tests++;
    if (hdmi_fs_ret !== 1'b1 || hdmi_fs_miss !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_pulses: got ret %b miss %b want 1 1",
                         hdmi_fs_ret, hdmi_fs_miss);
    end
    n_tests++;
    if (dut.state_q !== StWait) begin
      n_fail++; $display("FAIL same_cycle_state: got %0d want %0d", dut.state_q, StWait);
    end
    tick();
    fs_cycle();
    n_tests++;
    if (dut.state_q !== StActive || hdmi_raddr !== 9'h055 || hdmi_fs_miss !== 1'b0) begin
      n_fail++; $display("FAIL next_fs_load: got st %0d addr %h miss %b want %0d 055 0",
                         dut.state_q, hdmi_raddr, hdmi_fs_miss, StActive);
    end
  endtask

  task automatic test_reset_midline();
    hdmi_de = 1'b1;
    repeat (4) tick();
    #3;
    hdmi_rst_n = 1'b0;
    #1;
    n_tests++;
    if (hdmi_raddr !== 9'h000 || hdmi_raddr_g !== 9'h000 || hdmi_fs_toggle !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_addr: got %h/%h tog %b want 000/000 0",
                         hdmi_raddr, hdmi_raddr_g, hdmi_fs_toggle);
    end
    n_tests++;
    if (hdmi_data !== 24'h0 || hdmi_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_data: got %h/%b want 0/0", hdmi_data, hdmi_data_valid);
    end
    n_tests++;
    if (dut.state_q !== StIdle || hdmi_fs_ret !== 1'b0 || hdmi_fs_miss !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_state: got st %0d ret %b miss %b want %0d 0 0",
                         dut.state_q, hdmi_fs_ret, hdmi_fs_miss, StIdle);
    end
    hdmi_de = 1'b0;
    exp_tog = 1'b0;
    tick();
    hdmi_rst_n = 1'b1;
    tick();
    fs_cycle();
    n_tests++;
    if (dut.state_q !== StWait || hdmi_fs_miss !== 1'b0 || hdmi_fs_toggle !== exp_tog) begin
      n_fail++; $display("FAIL post_rst_fs: got st %0d miss %b tog %b want %0d 0 %b",
                         dut.state_q, hdmi_fs_miss, hdmi_fs_toggle, StWait, exp_tog);
    end
  endtask

  initial begin
    test_reset();
    test_first_fs();
    test_return();
    test_line();
    test_miss();
    test_same_cycle();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
